mips_control_ifid_pc_sequencer: RTL and testbench
=================================================

MIPS_CONTROL_IFID_PC_SEQUENCER -- requirements
Module: mips_control_ifid_pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 action  input  2  ID-stage PC action: 0 Inc, 1 Jump, 2 JumpR, 3 Branch.
REQ-005 condition  input  2  ID-stage branch condition: 0 None, 1 EQ, 2 NE, 3 reserved (treated as None).
REQ-006 id_valid  input  1  action/condition/operands describe a real instruction in ID.
REQ-007 id_pc  input  32  PC of the ID-stage instruction.
REQ-008 rs_value, rt_value  input  32 each  forwarded register operands.
REQ-009 imm16  input  16  branch offset; target26  input  26  jump index.
REQ-010 stall  input  1  hazard unit holds IF/ID; the ID instruction is not consumed.
REQ-011 imem_req  output  1; imem_addr  output  32; imem_ready  input  1 (request accepted); imem_valid  input  1; imem_data  input  32.
REQ-012 if_valid  output  1; if_pc  output  32; if_instr  output  32  fetched-instruction buffer presented to IF/ID.
REQ-013 flush_if  output  1  combinational; IF/ID register clears at this edge.

Function
REQ-014 The block SHALL be a 3-state FSM: REQ (request outstanding address), WAIT (one request accepted, awaiting data), HOLD (buffer full).
REQ-015 The block SHALL hold a 32-bit fetch register pc; imem_addr SHALL equal pc, and imem_req SHALL be 1 only in REQ.
REQ-016 In REQ, imem_ready=1 SHALL move the FSM to WAIT; otherwise the FSM SHALL stay in REQ.
REQ-017 In WAIT, imem_valid=1 SHALL load if_pc<=pc, if_instr<=imem_data, if_valid<=1, pc<=pc+4 (mod 2^32), and move the FSM to HOLD.
REQ-018 In HOLD with stall=0, the buffer is consumed: if_valid<=0 and the FSM moves to REQ; with stall=1 the buffer and state SHALL hold unchanged.
REQ-019 taken SHALL equal id_valid & ~stall & (action==Jump | action==JumpR | (action==Branch & ((condition==EQ & rs_value==rt_value) | (condition==NE & rs_value!=rt_value)))).
REQ-020 Targets: Jump = {(id_pc+4)[31:28], target26, 2'b00}; JumpR = rs_value; Branch = id_pc + 4 + (sign-extended imm16 << 2), 32-bit wraparound.
REQ-021 There is no delay slot; flush_if SHALL equal taken.
REQ-022 On taken, redirect SHALL override REQ-016..018 at that edge: pc<=target, if_valid<=0, FSM->REQ, with these exceptions:
- in WAIT without imem_valid, the FSM SHALL stay in WAIT with discard<=1;
- in REQ with imem_ready=1, the FSM SHALL go to WAIT with discard<=1.
REQ-023 In WAIT with discard=1, imem_valid=1 SHALL drop the data, clear discard and move the FSM to REQ; pc SHALL NOT increment.
REQ-024 In WAIT, imem_valid and taken in the same cycle SHALL drop the data, load the target and move the FSM to REQ.
REQ-025 At most one imem request SHALL be outstanding; imem_valid outside WAIT SHALL be ignored.
REQ-026 Branch with condition None, or action Inc, SHALL never redirect; id_valid=0 SHALL suppress taken.

Reset
REQ-027 Reset SHALL force pc=RESET_PC, FSM=REQ, discard=0, if_valid=0, if_pc=0 and if_instr=0, asynchronously, including mid-request.
REQ-028 After reset deasserts, imem_req SHALL be 1 with imem_addr=RESET_PC in the first cycle.

Verification
REQ-029 Sequential fetch: ready and valid 1 cycle later, stall=0 -> imem_addr 0,4,8; if_pc matches; one instruction per 3 cycles.
REQ-030 Taken beq: id_pc=0x100, imm16=0xFFFE, rs=rt=5 -> flush_if=1, next imem_addr=0x0FC; NE with rs=rt -> no redirect.
REQ-031 Jump: id_pc=0x8000_0010, target26=0x10 -> 0x8000_0040; JumpR with rs=0x1234 -> 0x1234.
REQ-032 Redirect while in WAIT: the stale imem_valid is dropped with if_valid staying 0, then the target is requested.
REQ-033 Stall in HOLD for 5 cycles -> if_valid, if_pc and if_instr stable and imem_req=0; release -> REQ next cycle.
REQ-034 Reset asserted in WAIT -> immediate if_valid=0; after release imem_addr=RESET_PC and the late response is ignored.

Source files
------------

// File: rtl/mips_control_ifid_pc_sequencer.sv
// -----------------------------------------------------------------------------
// mips_control_ifid_pc_sequencer
//
// Instruction-fetch sequencer for a 5-stage MIPS pipeline. It owns the fetch
// address register, issues one instruction-memory request at a time and
// presents the returned word to the IF/ID register through a one-entry buffer.
// Control transfers resolved in ID (j, jr, beq, bne) redirect fetch with no
// delay slot. The instruction already fetched behind the branch is flushed, and
// a response still in flight for the wrong path is dropped on arrival.
//
// Fetch FSM:
//   REQ  : imem_req=1 with imem_addr=pc, waiting for imem_ready
//   WAIT : one request accepted, waiting for imem_valid
//   HOLD : buffer full, waiting for IF/ID to consume it (stall=0)
// -----------------------------------------------------------------------------
module mips_control_ifid_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,

    // ID-stage control-transfer information
    input  logic [1:0]  action,
    input  logic [1:0]  condition,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic        stall,

    // Instruction memory port
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,

    // Fetched-instruction buffer towards IF/ID
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush_if
);

    // ID-stage PC action encoding
    typedef enum logic [1:0] {
        ACT_INC    = 2'd0,
        ACT_JUMP   = 2'd1,
        ACT_JUMPR  = 2'd2,
        ACT_BRANCH = 2'd3
    } action_e;

    // ID-stage branch condition encoding (3 is reserved and behaves as None)
    typedef enum logic [1:0] {
        COND_NONE = 2'd0,
        COND_EQ   = 2'd1,
        COND_NE   = 2'd2,
        COND_RSVD = 2'd3
    } cond_e;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state;
    logic [31:0] pc;        // address of the next instruction to fetch
    logic        discard;   // the outstanding response belongs to a squashed path

    logic        cond_met;
    logic        taken;
    logic [31:0] id_seq_pc;
    logic [31:0] branch_offset;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] redirect_pc;

    // -------------------------------------------------------------------------
    // Redirect decision and target
    // -------------------------------------------------------------------------

    // Resolve whether the ID instruction transfers control this cycle
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no
        // path through the block can leave it unassigned and infer a latch.
        cond_met = 1'b0;
        taken    = 1'b0;

        unique case (condition)
            COND_EQ:   cond_met = (rs_value == rt_value);
            COND_NE:   cond_met = (rs_value != rt_value);
            COND_NONE,
            COND_RSVD: cond_met = 1'b0;
            default:   cond_met = 1'b0;
        endcase

        // A stalled ID instruction is not consumed, so it must not redirect yet;
        // it will be re-presented and resolved once the stall releases.
        if (id_valid && !stall) begin
            unique case (action)
                ACT_JUMP,
                ACT_JUMPR:  taken = 1'b1;
                ACT_BRANCH: taken = cond_met;
                ACT_INC:    taken = 1'b0;
                default:    taken = 1'b0;
            endcase
        end
    end

    // Target arithmetic for every action; the mux below picks one
    always_comb begin
        id_seq_pc     = id_pc + 32'd4;
        branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
        jump_target   = {id_seq_pc[31:28], target26, 2'b00};
        branch_target = id_seq_pc + branch_offset;
        redirect_pc   = id_seq_pc;

        unique case (action)
            ACT_JUMP:   redirect_pc = jump_target;
            ACT_JUMPR:  redirect_pc = rs_value;
            ACT_BRANCH: redirect_pc = branch_target;
            ACT_INC:    redirect_pc = id_seq_pc;
            default:    redirect_pc = id_seq_pc;
        endcase
    end

    // No delay slot: whatever sits in IF/ID behind a taken transfer is wrong-path
    assign flush_if  = taken;

    // Memory port is a direct view of the fetch register and the FSM state
    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;

    // -------------------------------------------------------------------------
    // Fetch FSM, fetch register and instruction buffer
    // -------------------------------------------------------------------------

    // Advance fetch; a redirect from ID takes priority over normal sequencing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            discard  <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= 32'h0000_0000;
            if_instr <= 32'h0000_0000;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every branch
            // sees the pre-edge values and ordering between registers is irrelevant.
            unique case (state)
                S_REQ: begin
                    if (taken) begin
                        pc       <= redirect_pc;
                        if_valid <= 1'b0;
                        if (imem_ready) begin
                            // The old address was accepted at this very edge, so
                            // its response will arrive and must be thrown away.
                            state   <= S_WAIT;
                            discard <= 1'b1;
                        end else begin
                            state   <= S_REQ;
                        end
                    end else if (imem_ready) begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (taken) begin
                        pc       <= redirect_pc;
                        if_valid <= 1'b0;
                        if (imem_valid) begin
                            // Response arrives together with the redirect: drop it
                            // and go straight to requesting the target.
                            state   <= S_REQ;
                            discard <= 1'b0;
                        end else begin
                            // Only one request may be outstanding, so wait for the
                            // stale response before issuing the target fetch.
                            state   <= S_WAIT;
                            discard <= 1'b1;
                        end
                    end else if (imem_valid) begin
                        if (discard) begin
                            // Wrong-path word: pc already holds the target
                            state   <= S_REQ;
                            discard <= 1'b0;
                        end else begin
                            if_pc    <= pc;
                            if_instr <= imem_data;
                            if_valid <= 1'b1;
                            pc       <= pc + 32'd4;
                            state    <= S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    // taken already implies stall=0, so the buffer is free anyway
                    if (taken) begin
                        pc       <= redirect_pc;
                        if_valid <= 1'b0;
                        state    <= S_REQ;
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                        state    <= S_REQ;
                    end
                end

                default: begin
                    state   <= S_REQ;
                    discard <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_control_ifid_pc_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for mips_control_ifid_pc_sequencer.
//
// A behavioural model tracks the fetch engine as "is a request outstanding",
// "is that response stale" and "is the buffer full", and a negedge process
// compares every DUT output with it each cycle out of reset. Directed vectors
// drive the memory handshake and ID-stage inputs; literal checks at key points
// pin the model to hand-computed addresses.
// -----------------------------------------------------------------------------
module tb_mips_control_ifid_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic [1:0]  action;
    logic [1:0]  condition;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush_if;

    int tests_run    = 0;
    int tests_failed = 0;

    mips_control_ifid_pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clock      (clock),
        .reset      (reset),
        .action     (action),
        .condition  (condition),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .rs_value   (rs_value),
        .rt_value   (rt_value),
        .imm16      (imm16),
        .target26   (target26),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .flush_if   (flush_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic model_taken(input logic v, input logic s, input logic [1:0] a,
                                         input logic [1:0] c, input logic [31:0] rs,
                                         input logic [31:0] rt);
        if (!v || s) return 1'b0;
        if (a == 2'd1 || a == 2'd2) return 1'b1;
        if (a == 2'd3) return (c == 2'd1 && rs == rt) || (c == 2'd2 && rs != rt);
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_target(input logic [1:0] a, input logic [31:0] pc_id,
                                                 input logic [31:0] rs, input logic [15:0] imm,
                                                 input logic [25:0] t26);
        logic [31:0] next_pc;
        logic [31:0] offset;
        next_pc = pc_id + 32'd4;
        offset  = 32'($signed(imm)) * 32'd4;
        if (a == 2'd1) return (next_pc & 32'hF000_0000) | (32'(t26) * 32'd4);
        if (a == 2'd2) return rs;
        return next_pc + offset;
    endfunction

    logic [31:0] m_pc;
    logic        m_out;        // a request has been accepted and not yet answered
    logic        m_stale;      // that answer is for a squashed path
    logic        m_buf_valid;
    logic [31:0] m_buf_pc;
    logic [31:0] m_buf_instr;
    logic        m_req;
    logic        m_tk;
    logic [31:0] m_tgt;

    assign m_req = !m_out && !m_buf_valid;
    assign m_tk  = model_taken(id_valid, stall, action, condition, rs_value, rt_value);
    assign m_tgt = model_target(action, id_pc, rs_value, imm16, target26);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pc        <= RESET_PC;
            m_out       <= 1'b0;
            m_stale     <= 1'b0;
            m_buf_valid <= 1'b0;
            m_buf_pc    <= 32'h0;
            m_buf_instr <= 32'h0;
        end else if (m_tk) begin
            m_pc        <= m_tgt;
            m_buf_valid <= 1'b0;
            if (m_req && imem_ready) begin
                m_out   <= 1'b1;
                m_stale <= 1'b1;
            end else if (m_out && !imem_valid) begin
                m_stale <= 1'b1;
            end else if (m_out) begin
                m_out   <= 1'b0;
                m_stale <= 1'b0;
            end
        end else if (m_req) begin
            if (imem_ready) begin
                m_out   <= 1'b1;
                m_stale <= 1'b0;
            end
        end else if (m_out) begin
            if (imem_valid) begin
                m_out   <= 1'b0;
                m_stale <= 1'b0;
                if (!m_stale) begin
                    m_buf_valid <= 1'b1;
                    m_buf_pc    <= m_pc;
                    m_buf_instr <= imem_data;
                    m_pc        <= m_pc + 32'd4;
                end
            end
        end else if (m_buf_valid && !stall) begin
            m_buf_valid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (!reset) begin
            check("imem_req",  32'(imem_req), 32'(m_req));
            check("imem_addr", imem_addr,     m_pc);
            check("if_valid",  32'(if_valid), 32'(m_buf_valid));
            check("if_pc",     if_pc,         m_buf_pc);
            check("if_instr",  if_instr,      m_buf_instr);
            check("flush_if",  32'(flush_if), 32'(m_tk));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic rdy, input logic vld, input logic stl);
        imem_ready = rdy;
        imem_valid = vld;
        stall      = stl;
        imem_data  = {16'hBEEF, m_pc[15:0]};
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic [1:0] a, input logic [1:0] c, input logic [31:0] pc_id,
                          input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                          input logic [25:0] t26);
        id_valid  = 1'b1;
        action    = a;
        condition = c;
        id_pc     = pc_id;
        rs_value  = rs;
        rt_value  = rt;
        imm16     = imm;
        target26  = t26;
    endtask

    task automatic clr_id();
        id_valid = 1'b0;
        action   = 2'd0;
        condition = 2'd0;
    endtask

    task automatic fetch_one();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        imem_ready = 1'b0; imem_valid = 1'b0; imem_data = 32'h0; stall = 1'b0;
        id_valid = 1'b0; action = 2'd0; condition = 2'd0; id_pc = 32'h0;
        rs_value = 32'h0; rt_value = 32'h0; imm16 = 16'h0; target26 = 26'h0;

        #2;
        check("reset if_valid", 32'(if_valid), 32'h0);
        check("reset if_pc",    if_pc,         32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("first req",  32'(imem_req), 32'h1);
        check("first addr", imem_addr,     RESET_PC);

        // Sequential fetch: 0, 4, 8, one instruction every 3 cycles
        for (int i = 0; i < 3; i++) begin
            check("seq addr", imem_addr, 32'(i * 4));
            fetch_one();
            check("seq if_valid", 32'(if_valid), 32'h1);
            check("seq if_pc",    if_pc,         32'(i * 4));
            check("seq if_instr", if_instr,      32'hBEEF_0000 | 32'(i * 4));
            cyc(1'b0, 1'b0, 1'b0);
        end
        check("seq next addr", imem_addr, 32'h0000_000C);

        // Taken beq from HOLD: 0x100 + 4 - 8 = 0x0FC
        fetch_one();
        set_id(2'd3, 2'd1, 32'h0000_0100, 32'd5, 32'd5, 16'hFFFE, 26'h0);
        #1 check("beq flush", 32'(flush_if), 32'h1);
        cyc(1'b0, 1'b0, 1'b0);
        clr_id();
        check("beq addr", imem_addr, 32'h0000_00FC);
        check("beq buf",  32'(if_valid), 32'h0);

        // bne with equal operands: no redirect
        set_id(2'd3, 2'd2, 32'h0000_0100, 32'd5, 32'd5, 16'hFFFE, 26'h0);
        #1 check("bne flush", 32'(flush_if), 32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        clr_id();
        check("bne addr", imem_addr, 32'h0000_00FC);

        // j: region bits from id_pc+4 -> 0x8000_0040
        set_id(2'd1, 2'd0, 32'h8000_0010, 32'h0, 32'h0, 16'h0, 26'h10);
        cyc(1'b0, 1'b0, 1'b0);
        clr_id();
        check("j addr", imem_addr, 32'h8000_0040);

        // jr rs=0x1234
        set_id(2'd2, 2'd0, 32'h0000_0040, 32'h1234, 32'h0, 16'h0, 26'h0);
        cyc(1'b0, 1'b0, 1'b0);
        clr_id();
        check("jr addr", imem_addr, 32'h0000_1234);

        // Redirect while WAIT without data: stale response dropped, then target
        cyc(1'b1, 1'b0, 1'b0);
        set_id(2'd3, 2'd1, 32'h0000_0200, 32'd7, 32'd7, 16'h0010, 26'h0);
        cyc(1'b0, 1'b0, 1'b0);
        clr_id();
        check("wait redir req",  32'(imem_req), 32'h0);
        check("wait redir addr", imem_addr,     32'h0000_0244);
        cyc(1'b0, 1'b1, 1'b0);
        check("stale dropped", 32'(if_valid), 32'h0);
        check("target req",    32'(imem_req), 32'h1);
        check("target addr",   imem_addr,     32'h0000_0244);
        fetch_one();
        check("target if_pc", if_pc, 32'h0000_0244);
        cyc(1'b0, 1'b0, 1'b0);

        // Redirect in REQ at the same edge the request is accepted
        set_id(2'd2, 2'd0, 32'h0000_0244, 32'h0000_0400, 32'h0, 16'h0, 26'h0);
        cyc(1'b1, 1'b0, 1'b0);
        clr_id();
        check("req+ready redir", 32'(imem_req), 32'h0);
        cyc(1'b0, 1'b1, 1'b0);
        check("req+ready drop", 32'(if_valid), 32'h0);
        check("req+ready addr", imem_addr,     32'h0000_0400);

        // Redirect in WAIT coinciding with imem_valid
        cyc(1'b1, 1'b0, 1'b0);
        set_id(2'd2, 2'd0, 32'h0000_0300, 32'h0000_0500, 32'h0, 16'h0, 26'h0);
        cyc(1'b0, 1'b1, 1'b0);
        clr_id();
        check("wait+valid valid", 32'(if_valid), 32'h0);
        check("wait+valid req",   32'(imem_req), 32'h1);
        check("wait+valid addr",  imem_addr,     32'h0000_0500);

        // Never-redirect cases: Inc, Branch/None, Branch/reserved, id_valid=0
        set_id(2'd0, 2'd1, 32'h0, 32'd1, 32'd1, 16'h0040, 26'h0);
        cyc(1'b0, 1'b0, 1'b0);
        set_id(2'd3, 2'd0, 32'h0, 32'd1, 32'd1, 16'h0040, 26'h0);
        cyc(1'b0, 1'b0, 1'b0);
        set_id(2'd3, 2'd3, 32'h0, 32'd1, 32'd1, 16'h0040, 26'h0);
        cyc(1'b0, 1'b0, 1'b0);
        set_id(2'd1, 2'd0, 32'h0, 32'd1, 32'd1, 16'h0040, 26'h3F);
        id_valid = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        clr_id();
        check("no redir addr", imem_addr, 32'h0000_0500);

        // Stall in HOLD for 5 cycles, with a jump in ID that must be suppressed
        fetch_one();
        set_id(2'd1, 2'd0, 32'h0, 32'h0, 32'h0, 16'h0, 26'h100);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1);
        check("stall if_valid", 32'(if_valid), 32'h1);
        check("stall if_pc",    if_pc,         32'h0000_0500);
        check("stall if_instr", if_instr,      32'hBEEF_0500);
        check("stall req",      32'(imem_req), 32'h0);
        clr_id();
        cyc(1'b0, 1'b0, 1'b0);
        check("release req",  32'(imem_req), 32'h1);
        check("release addr", imem_addr,     32'h0000_0504);

        // pc+4 wraps at 2^32
        set_id(2'd2, 2'd0, 32'h0, 32'hFFFF_FFFC, 32'h0, 16'h0, 26'h0);
        cyc(1'b0, 1'b0, 1'b0);
        clr_id();
        fetch_one();
        check("wrap if_pc", if_pc,     32'hFFFF_FFFC);
        check("wrap addr",  imem_addr, 32'h0000_0000);

        // Asynchronous reset while HOLD
        cyc(1'b0, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst hold if_valid", 32'(if_valid), 32'h0);
        check("rst hold if_pc",    if_pc,         32'h0);
        check("rst hold if_instr", if_instr,      32'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Asynchronous reset while WAIT; late response ignored afterwards
        set_id(2'd2, 2'd0, 32'h0, 32'h0000_0800, 32'h0, 16'h0, 26'h0);
        cyc(1'b0, 1'b0, 1'b0);
        clr_id();
        cyc(1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("rst wait if_valid", 32'(if_valid), 32'h0);
        check("rst wait req",      32'(imem_req), 32'h1);
        check("rst wait addr",     imem_addr,     RESET_PC);
        @(posedge clock);
        #1 reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        check("late resp if_valid", 32'(if_valid), 32'h0);
        check("late resp req",      32'(imem_req), 32'h1);
        check("late resp addr",     imem_addr,     RESET_PC);
        fetch_one();
        check("post rst if_pc", if_pc, RESET_PC);
        cyc(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
